// File: rtl/cache_controller_pkg.sv
// rtl/cache_controller_pkg.sv - shared cache types: memory operations and controller states
package torrence_types;

   // Requester and higher-memory operation encoding
   typedef enum logic {
      LOAD  = 1'b0,
      STORE = 1'b1
   } memory_operation_e;

   // Cache controller sequencing states
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } cache_state_e;

endpackage

// File: rtl/cache_controller_if.sv
// rtl/cache_controller_if.sv - control/status bundle between cache controller and cache datapath
interface cache_internal_if;

   // controller -> datapath
   logic miss_recovery_mode;
   logic set_hmem_block_address;
   logic use_victim_tag_for_hmem_block_address;
   logic process_lru_counters;
   logic clear_selected_valid_bit;
   logic finish_new_line_install;
   logic clear_selected_dirty_bit;
   logic set_selected_dirty_bit;
   logic perform_write;
   logic reset_counter;
   logic decrement_counter;
   logic count_hit;
   logic count_miss;
   logic count_read;
   logic count_write;

   // datapath -> controller
   logic valid_block_match;
   logic valid_dirty_bit;
   logic counter_done;

   modport controller (
      output miss_recovery_mode, set_hmem_block_address,
             use_victim_tag_for_hmem_block_address, process_lru_counters,
             clear_selected_valid_bit, finish_new_line_install,
             clear_selected_dirty_bit, set_selected_dirty_bit, perform_write,
             reset_counter, decrement_counter, count_hit, count_miss,
             count_read, count_write,
      input  valid_block_match, valid_dirty_bit, counter_done
   );

   modport datapath (
      input  miss_recovery_mode, set_hmem_block_address,
             use_victim_tag_for_hmem_block_address, process_lru_counters,
             clear_selected_valid_bit, finish_new_line_install,
             clear_selected_dirty_bit, set_selected_dirty_bit, perform_write,
             reset_counter, decrement_counter, count_hit, count_miss,
             count_read, count_write,
      output valid_block_match, valid_dirty_bit, counter_done
   );

endinterface

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - hit/miss sequencing FSM with dirty writeback and line refill
module cache_controller
   import torrence_types::*;
#(
   parameter int LINE_SIZE = 32,
   parameter int READ_ONLY = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   input  memory_operation_e req_operation,
   output logic              req_fulfilled,
   output logic              hmem_req_valid,
   output memory_operation_e hmem_req_operation,
   input  logic              hmem_req_fulfilled,
   cache_internal_if.controller internal_if
);

   // The beat counter lives in the datapath; the line size only has to be whole words.
   if (LINE_SIZE < 4 || (LINE_SIZE % 4) != 0) begin : g_bad_line_size
      $error("cache_controller: LINE_SIZE must be a positive multiple of 4");
   end

   localparam bit HAS_DIRTY = (READ_ONLY == 0);

   cache_state_e state_q, state_d;
   logic         replay_q, replay_d;

   // State and replay registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         replay_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         replay_q <= replay_d;
      end
   end

   // Next state and all control outputs; everything is held at 0 while reset is asserted
   always_comb begin
      state_d            = state_q;
      replay_d           = replay_q;
      req_fulfilled      = 1'b0;
      hmem_req_valid     = 1'b0;
      hmem_req_operation = LOAD;
      internal_if.miss_recovery_mode                    = 1'b0;
      internal_if.set_hmem_block_address                = 1'b0;
      internal_if.use_victim_tag_for_hmem_block_address = 1'b0;
      internal_if.process_lru_counters                  = 1'b0;
      internal_if.clear_selected_valid_bit              = 1'b0;
      internal_if.finish_new_line_install               = 1'b0;
      internal_if.clear_selected_dirty_bit              = 1'b0;
      internal_if.set_selected_dirty_bit                = 1'b0;
      internal_if.perform_write                         = 1'b0;
      internal_if.reset_counter                         = 1'b0;
      internal_if.decrement_counter                     = 1'b0;
      internal_if.count_hit                             = 1'b0;
      internal_if.count_miss                            = 1'b0;
      internal_if.count_read                            = 1'b0;
      internal_if.count_write                           = 1'b0;

      if (reset_n) begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  // The post-refill retry is the same request; it must not be counted twice.
                  if (!replay_q) begin
                     internal_if.count_read  = (req_operation == LOAD);
                     internal_if.count_write = (req_operation == STORE);
                  end
                  if (!HAS_DIRTY && req_operation == STORE) begin
                     // A read-only cache acknowledges stores without touching the array.
                     req_fulfilled = 1'b1;
                     replay_d      = 1'b0;
                  end else if (internal_if.valid_block_match) begin
                     req_fulfilled                    = 1'b1;
                     internal_if.process_lru_counters = 1'b1;
                     internal_if.count_hit            = !replay_q;
                     if (req_operation == STORE) begin
                        internal_if.perform_write          = 1'b1;
                        internal_if.set_selected_dirty_bit = 1'b1;
                     end
                     replay_d = 1'b0;
                  end else begin
                     internal_if.count_miss             = !replay_q;
                     internal_if.set_hmem_block_address = 1'b1;
                     internal_if.reset_counter          = 1'b1;
                     if (HAS_DIRTY && internal_if.valid_dirty_bit) begin
                        internal_if.use_victim_tag_for_hmem_block_address = 1'b1;
                        state_d = WRITEBACK;
                     end else begin
                        // Invalidate first so an aborted refill never leaves a half-filled valid line.
                        internal_if.clear_selected_valid_bit = 1'b1;
                        state_d = ALLOCATE;
                     end
                  end
               end
            end

            WRITEBACK: begin
               internal_if.miss_recovery_mode = 1'b1;
               hmem_req_valid                 = 1'b1;
               hmem_req_operation             = STORE;
               if (hmem_req_fulfilled) begin
                  internal_if.decrement_counter = 1'b1;
                  if (internal_if.counter_done) begin
                     // Last victim word out: retarget the address to the requested line.
                     internal_if.clear_selected_dirty_bit = 1'b1;
                     internal_if.clear_selected_valid_bit = 1'b1;
                     internal_if.set_hmem_block_address   = 1'b1;
                     internal_if.reset_counter            = 1'b1;
                     state_d = ALLOCATE;
                  end
               end
            end

            ALLOCATE: begin
               internal_if.miss_recovery_mode = 1'b1;
               hmem_req_valid                 = 1'b1;
               hmem_req_operation             = LOAD;
               if (hmem_req_fulfilled) begin
                  internal_if.perform_write     = 1'b1;
                  internal_if.decrement_counter = 1'b1;
                  if (internal_if.counter_done) begin
                     internal_if.finish_new_line_install = 1'b1;
                     replay_d = 1'b1;
                     state_d  = IDLE;
                  end
               end
            end

            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed scoreboard bench for cache_controller
module tb_cache_controller;
   import torrence_types::*;

   localparam int WORDS = 8;

   typedef struct {
      memory_operation_e op;
      int                tag;
      int                word;
   } beat_t;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              req_valid;
   memory_operation_e req_operation;
   logic              req_fulfilled;
   logic              hmem_req_valid;
   memory_operation_e hmem_req_operation;
   logic              hmem_req_fulfilled;

   logic              ro_req_valid;
   memory_operation_e ro_req_operation;
   logic              ro_req_fulfilled;
   logic              ro_hmem_req_valid;
   memory_operation_e ro_hmem_req_operation;
   logic              ro_hmem_req_fulfilled;

   cache_internal_if ci ();
   cache_internal_if ci_ro ();

   cache_controller #(.LINE_SIZE(32), .READ_ONLY(0)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_operation(req_operation), .req_fulfilled(req_fulfilled),
      .hmem_req_valid(hmem_req_valid), .hmem_req_operation(hmem_req_operation),
      .hmem_req_fulfilled(hmem_req_fulfilled), .internal_if(ci.controller)
   );

   cache_controller #(.LINE_SIZE(32), .READ_ONLY(1)) dut_ro (
      .clk(clk), .reset_n(reset_n),
      .req_valid(ro_req_valid), .req_operation(ro_req_operation), .req_fulfilled(ro_req_fulfilled),
      .hmem_req_valid(ro_hmem_req_valid), .hmem_req_operation(ro_hmem_req_operation),
      .hmem_req_fulfilled(ro_hmem_req_fulfilled), .internal_if(ci_ro.controller)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // datapath / higher-memory model state
   logic line_valid, line_dirty;
   int   line_tag, hmem_tag, cnt, req_tag;
   int   hmem_wait, hmem_wait_left;
   beat_t beat_q[$];

   // observation tallies
   int n_read, n_write, n_hit, n_miss, n_pw, n_finish, n_beats;
   logic fulfilled_seen, snap_lru, snap_pw, snap_sd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [17:0] all_out();
      return {req_fulfilled, hmem_req_valid, hmem_req_operation,
              ci.miss_recovery_mode, ci.set_hmem_block_address,
              ci.use_victim_tag_for_hmem_block_address, ci.process_lru_counters,
              ci.clear_selected_valid_bit, ci.finish_new_line_install,
              ci.clear_selected_dirty_bit, ci.set_selected_dirty_bit, ci.perform_write,
              ci.reset_counter, ci.decrement_counter, ci.count_hit, ci.count_miss,
              ci.count_read, ci.count_write};
   endfunction

   task automatic drive_dp();
      ci.valid_block_match = line_valid && (line_tag == req_tag);
      ci.valid_dirty_bit   = line_valid && line_dirty;
      ci.counter_done      = (cnt == 0);
   endtask

   // One clock: respond, observe, then apply the datapath model after the edge
   task automatic cyc();
      beat_t b;
      logic  c_rst, c_dec, c_set, c_vic, c_clrv, c_clrd, c_setd, c_fin;
      #1;
      hmem_req_fulfilled = 1'b0;
      if (hmem_req_valid) begin
         if (hmem_wait_left == 0) begin
            hmem_req_fulfilled = 1'b1;
            hmem_wait_left     = hmem_wait;
         end else begin
            hmem_wait_left--;
         end
      end
      #1;
      if (ci.count_read)  n_read++;
      if (ci.count_write) n_write++;
      if (ci.count_hit)   n_hit++;
      if (ci.count_miss)  n_miss++;
      if (ci.perform_write) n_pw++;
      if (ci.finish_new_line_install) n_finish++;
      if (req_fulfilled) begin
         fulfilled_seen = 1'b1;
         snap_lru = ci.process_lru_counters;
         snap_pw  = ci.perform_write;
         snap_sd  = ci.set_selected_dirty_bit;
      end
      if (hmem_req_fulfilled) begin
         n_beats++;
         if (beat_q.size() == 0) begin
            check("unexpected_beat", 32'd1, 32'd0);
         end else begin
            b = beat_q.pop_front();
            check("beat_op", 32'(hmem_req_operation), 32'(b.op));
            check("beat_tag", hmem_tag, b.tag);
            check("beat_word", cnt, b.word);
         end
      end
      c_rst = ci.reset_counter;            c_dec  = ci.decrement_counter;
      c_set = ci.set_hmem_block_address;   c_vic  = ci.use_victim_tag_for_hmem_block_address;
      c_clrv = ci.clear_selected_valid_bit; c_clrd = ci.clear_selected_dirty_bit;
      c_setd = ci.set_selected_dirty_bit;  c_fin  = ci.finish_new_line_install;
      @(posedge clk);
      @(negedge clk);
      if (c_rst) cnt = WORDS - 1;
      else if (c_dec) cnt--;
      if (c_fin) begin
         line_valid = 1'b1;
         line_tag   = hmem_tag;
         line_dirty = 1'b0;
      end
      if (c_set) hmem_tag = c_vic ? line_tag : req_tag;
      if (c_clrv) line_valid = 1'b0;
      if (c_clrd) line_dirty = 1'b0;
      if (c_setd) line_dirty = 1'b1;
      hmem_req_fulfilled = 1'b0;
      drive_dp();
   endtask

   // Issue a request, predict its higher-memory beats, and run it to completion
   task automatic start_req(input memory_operation_e op, input int addr);
      req_tag       = addr >> 5;
      req_operation = op;
      req_valid     = 1'b1;
      drive_dp();
      if (!(line_valid && line_tag == req_tag)) begin
         if (line_valid && line_dirty)
            for (int w = WORDS - 1; w >= 0; w--) beat_q.push_back('{STORE, line_tag, w});
         for (int w = WORDS - 1; w >= 0; w--) beat_q.push_back('{LOAD, req_tag, w});
      end
      fulfilled_seen = 1'b0;
   endtask

   task automatic do_req(input memory_operation_e op, input int addr, input int budget,
                         output int lat);
      start_req(op, addr);
      lat = 0;
      while (!fulfilled_seen && lat < budget) begin
         cyc();
         lat++;
      end
      check("fulfilled_within_budget", 32'(fulfilled_seen), 32'd1);
      req_valid = 1'b0;
      check("beat_queue_drained", beat_q.size(), 0);
   endtask

   int lat, r0, w0, h0, m0, p0, f0, guard;

   initial begin
      reset_n = 1'b0; req_valid = 1'b1; req_operation = LOAD; hmem_req_fulfilled = 1'b0;
      ro_req_valid = 1'b0; ro_req_operation = LOAD; ro_hmem_req_fulfilled = 1'b0;
      ci_ro.valid_block_match = 1'b0; ci_ro.valid_dirty_bit = 1'b1; ci_ro.counter_done = 1'b0;
      line_valid = 1'b1; line_dirty = 1'b0; line_tag = 32'h100 >> 5;
      hmem_tag = 0; cnt = WORDS - 1; req_tag = 32'h100 >> 5;
      hmem_wait = 0; hmem_wait_left = 0;
      n_read = 0; n_write = 0; n_hit = 0; n_miss = 0; n_pw = 0; n_finish = 0; n_beats = 0;
      fulfilled_seen = 1'b0; snap_lru = 1'b0; snap_pw = 1'b0; snap_sd = 1'b0;
      drive_dp();
      @(negedge clk);

      // Reset held two cycles with a hitting request pending: outputs stay quiet
      for (int i = 0; i < 2; i++) begin
         #2;
         check("reset_outputs_zero", 32'(all_out()), 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      reset_n = 1'b1; req_valid = 1'b0;
      cyc();
      check("post_reset_idle_quiet", 32'(all_out()), 32'd0);
      n_read = 0; n_write = 0; n_hit = 0; n_miss = 0; n_pw = 0; n_finish = 0;

      // LOAD hit at 0x100
      do_req(LOAD, 32'h100, 5, lat);
      check("hit_latency", lat, 1);
      check("hit_read_count", n_read, 1);
      check("hit_hit_count", n_hit, 1);
      check("hit_miss_count", n_miss, 0);
      check("hit_lru", 32'(snap_lru), 32'd1);
      check("hit_load_no_write", 32'(snap_pw), 32'd0);

      // Clean LOAD miss at 0x200 with single-cycle higher-memory beats
      r0 = n_read; h0 = n_hit; m0 = n_miss; p0 = n_pw; f0 = n_finish;
      do_req(LOAD, 32'h200, 40, lat);
      check("clean_miss_latency", lat, 10);
      check("clean_miss_reads", n_read - r0, 1);
      check("clean_miss_misses", n_miss - m0, 1);
      check("clean_miss_hits", n_hit - h0, 0);
      check("clean_miss_writes", n_pw - p0, WORDS);
      check("clean_miss_install", n_finish - f0, 1);

      // STORE hit then LOAD hit on consecutive cycles
      w0 = n_write; h0 = n_hit;
      do_req(STORE, 32'h200, 5, lat);
      check("store_hit_latency", lat, 1);
      check("store_hit_write", 32'(snap_pw), 32'd1);
      check("store_hit_dirty", 32'(snap_sd), 32'd1);
      do_req(LOAD, 32'h200, 5, lat);
      check("b2b_hit_latency", lat, 1);
      check("b2b_hit_count", n_hit - h0, 2);
      check("store_write_count", n_write - w0, 1);

      // Dirty STORE miss at 0x300, every beat stretched by one wait cycle
      hmem_wait = 1; hmem_wait_left = 1;
      w0 = n_write; h0 = n_hit; m0 = n_miss; p0 = n_pw;
      do_req(STORE, 32'h300, 80, lat);
      check("dirty_miss_latency", lat, 1 + 2 * 2 * WORDS + 1);
      check("dirty_miss_misses", n_miss - m0, 1);
      check("dirty_miss_write_count", n_write - w0, 1);
      check("dirty_miss_hits", n_hit - h0, 0);
      check("dirty_miss_writes", n_pw - p0, WORDS + 1);
      check("replay_store_write", 32'(snap_pw), 32'd1);
      check("replay_store_dirty", 32'(snap_sd), 32'd1);

      // Reset after the third refill beat of a writeback+refill miss
      hmem_wait = 0; hmem_wait_left = 0;
      start_req(LOAD, 32'h400);
      n_beats = 0; guard = 0;
      while (n_beats < WORDS + 3 && guard < 40) begin
         cyc();
         guard++;
      end
      check("reached_third_refill_beat", n_beats, WORDS + 3);
      check("mid_allocate_busy", 32'(hmem_req_valid), 32'd1);
      reset_n = 1'b0; req_valid = 1'b0;
      cyc();
      check("reset_mid_allocate_quiet", 32'(all_out()), 32'd0);
      reset_n = 1'b1;
      cyc();
      check("after_abort_idle_quiet", 32'(all_out()), 32'd0);
      beat_q.delete();
      m0 = n_miss; p0 = n_pw;
      do_req(LOAD, 32'h400, 40, lat);
      check("reissue_latency", lat, 10);
      check("reissue_miss", n_miss - m0, 1);
      check("reissue_writes", n_pw - p0, WORDS);

      // Read-only variant: STOREs complete at once, dirty victims never write back
      ro_req_valid = 1'b1; ro_req_operation = STORE;
      #2;
      check("ro_store_fulfilled", 32'(ro_req_fulfilled), 32'd1);
      check("ro_store_count_write", 32'(ci_ro.count_write), 32'd1);
      check("ro_store_no_write", 32'(ci_ro.perform_write), 32'd0);
      check("ro_store_no_dirty", 32'(ci_ro.set_selected_dirty_bit), 32'd0);
      check("ro_store_no_hmem", 32'(ro_hmem_req_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      ro_req_operation = LOAD;
      #2;
      check("ro_miss_count", 32'(ci_ro.count_miss), 32'd1);
      check("ro_miss_no_victim", 32'(ci_ro.use_victim_tag_for_hmem_block_address), 32'd0);
      check("ro_miss_invalidate", 32'(ci_ro.clear_selected_valid_bit), 32'd1);
      @(posedge clk);
      @(negedge clk);
      ro_req_valid = 1'b0;
      #2;
      check("ro_fill_valid", 32'(ro_hmem_req_valid), 32'd1);
      check("ro_fill_is_load", 32'(ro_hmem_req_operation), 32'(LOAD));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
